// File: rtl/line_mem_responder.sv
// line_mem_responder: line-organised main-memory model answering the data
// cache's 256-bit line interface after a fixed access latency.
// Optional build macro: MEM_RANGE_CHECK_EN adds err_o. With it, a request whose
// address has bits set above the array range is flagged in its ack cycle. Such
// a request does not write the array, and a read of that kind returns zero.
module line_mem_responder #(
   parameter int unsigned LATENCY = 10,
   parameter int unsigned DEPTH   = 512,
   parameter int unsigned IDX_W   = 9
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         enable_i,
   input  logic         write_i,
   input  logic [31:0]  addr_i,
   input  logic [255:0] data_i,
   output logic         ack_o,
   output logic [255:0] data_o
`ifdef MEM_RANGE_CHECK_EN
   ,
   output logic         err_o
`endif
);

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

   state_t             state_q, state_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q;
   logic               write_q;
   logic [255:0]       data_q;
   logic               oor_q;

   logic               cap;
   logic               go_ack;
   logic [IDX_W-1:0]   idx_sel;
   logic               write_sel;
   logic               oor_sel;
   logic               oor_in;

   logic [255:0]       mem [DEPTH];

   // The byte offset and the bits above the line index never select a line.
   logic               unused_addr_bits;
   assign unused_addr_bits = ^{addr_i[4:0], addr_i[31:IDX_W+5]};

   // Out-of-range detection on the incoming address.
`ifdef MEM_RANGE_CHECK_EN
   assign oor_in = (addr_i[31:IDX_W+5] != '0);
`else
   assign oor_in = 1'b0;
`endif

   // Next-state, counter and completion decode.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cap       = 1'b0;
      go_ack    = 1'b0;
      idx_sel   = idx_q;
      write_sel = write_q;
      oor_sel   = oor_q;
      unique case (state_q)
         IDLE: begin
            if (enable_i) begin
               cap       = 1'b1;
               cnt_d     = 8'(LATENCY - 1);
               idx_sel   = addr_i[IDX_W+4:5];
               write_sel = write_i;
               oor_sel   = oor_in;
               if (LATENCY == 1) begin
                  state_d = ACK;
                  go_ack  = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (!enable_i) begin
               state_d = IDLE;
            end else if (cnt_q == 8'd1) begin
               state_d = ACK;
               go_ack  = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, request latch and registered response outputs.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         write_q <= 1'b0;
         data_q  <= '0;
         oor_q   <= 1'b0;
         ack_o   <= 1'b0;
         data_o  <= '0;
`ifdef MEM_RANGE_CHECK_EN
         err_o   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (cap) begin
            idx_q   <= addr_i[IDX_W+4:5];
            write_q <= write_i;
            data_q  <= data_i;
            oor_q   <= oor_in;
         end
         ack_o <= go_ack;
         if (go_ack && !write_sel)
            data_o <= oor_sel ? '0 : mem[idx_sel];
`ifdef MEM_RANGE_CHECK_EN
         err_o <= go_ack && oor_sel;
`endif
      end
   end

   // Line write is committed at the edge that leaves ACK. No read can sample
   // the array before that edge. A reset during ACK forces the state to IDLE
   // asynchronously, so the commit never fires.
   always_ff @(posedge clk_i) begin
      if (state_q == ACK && write_q && !oor_q)
         mem[idx_q] <= data_q;
   end

endmodule

// File: tb/tb_line_mem_responder.sv
// tb_line_mem_responder: randomized and directed traffic against a line-array
// reference model. Expected responses are queued at issue time. A monitor pops
// one entry per ack and compares it with the DUT outputs.
module tb_line_mem_responder;

   localparam int unsigned L     = 10;
   localparam int unsigned DEPTH = 512;
   localparam int unsigned IDX_W = 9;

   logic         clk = 1'b0;
   logic         rst_i = 1'b0;
   logic         enable_i = 1'b0;
   logic         write_i = 1'b0;
   logic [31:0]  addr_i = '0;
   logic [255:0] data_i = '0;
   logic         ack_o;
   logic [255:0] data_o;
`ifdef MEM_RANGE_CHECK_EN
   logic         err_o;
`endif

   line_mem_responder #(.LATENCY(L), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
      .clk_i    (clk),
      .rst_i    (rst_i),
      .enable_i (enable_i),
      .write_i  (write_i),
      .addr_i   (addr_i),
      .data_i   (data_i),
      .ack_o    (ack_o),
      .data_o   (data_o)
`ifdef MEM_RANGE_CHECK_EN
      ,
      .err_o    (err_o)
`endif
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      int unsigned  cyc;
      logic [255:0] data;
      bit           err;
   } exp_t;

   exp_t         sbq[$];
   exp_t         mon_e;
   logic [255:0] ref_mem [int unsigned];
   logic [255:0] last_read = '0;
   int unsigned  next_ok = 0;
   int           compared = 0;
   int           mismatched = 0;

   function automatic bit out_of_range(logic [31:0] a);
`ifdef MEM_RANGE_CHECK_EN
      return (a >> (IDX_W + 5)) != 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic int unsigned line_of(logic [31:0] a);
      return (int'(a) >>> 0 == 0) ? 0 : (32'(a) / 32) % DEPTH;
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic chk_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int unsigned act, input int unsigned exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Issue one request and hold it until the ack appears. The call starts and
   // ends on a falling edge. The reference model is updated here in request order.
   task automatic issue(input bit wr, input logic [31:0] a, input logic [255:0] d);
      exp_t        e;
      int unsigned acc;
      int unsigned n;
      write_i  = wr;
      addr_i   = a;
      data_i   = d;
      enable_i = 1'b1;
      acc   = (cyc + 1 > next_ok) ? cyc + 1 : next_ok;
      e.cyc = acc + L - 1;
      e.err = out_of_range(a);
      if (wr) begin
         if (!e.err) ref_mem[line_of(a)] = d;
         e.data = last_read;
      end else begin
         e.data    = e.err ? '0 : ref_mem[line_of(a)];
         last_read = e.data;
      end
      sbq.push_back(e);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ack_o && n < L + 5);
      if (!ack_o) begin
         compared++;
         mismatched++;
         $display("FAIL ack_timeout @cyc %0d: no ack within %0d cycles, expected ack at cycle %0d", cyc, n, e.cyc);
      end
      next_ok = cyc + 2;
   endtask

   // Start a request, then withdraw it k cycles after acceptance, before it can complete.
   task automatic abort_req(input bit wr, input logic [31:0] a, input logic [255:0] d, input int unsigned k);
      int unsigned acc;
      write_i  = wr;
      addr_i   = a;
      data_i   = d;
      enable_i = 1'b1;
      acc = (cyc + 1 > next_ok) ? cyc + 1 : next_ok;
      while (cyc < acc + k) @(negedge clk);
      enable_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic idle(input int unsigned n);
      enable_i = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Scoreboard monitor: each ack must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (ack_o) begin
         if (sbq.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL spurious_ack @cyc %0d: ack_o=1 but no request outstanding", cyc);
         end else begin
            mon_e = sbq.pop_front();
            chk_int("ack_cycle", cyc, mon_e.cyc);
            chk_vec("data_o", data_o, mon_e.data);
`ifdef MEM_RANGE_CHECK_EN
            chk_int("err_o", 32'(err_o), 32'(mon_e.err));
`endif
         end
      end
`ifdef MEM_RANGE_CHECK_EN
      else if (err_o === 1'b1) begin
         compared++;
         mismatched++;
         $display("FAIL err_without_ack @cyc %0d: err_o=1 expected 0", cyc);
      end
`endif
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] a5, dc;
      logic [31:0]  a;
      int unsigned  ln, acc;
      a5 = {8{32'hA5A5_0001}};

      // Reset held with a request pending
      write_i  = 1'b1;
      addr_i   = 32'h0000_0400;
      data_i   = a5;
      enable_i = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk_int("reset_ack", 32'(ack_o), 0);
         chk_vec("reset_data", data_o, '0);
      end
      rst_i = 1'b1;
      issue(1'b1, 32'h0000_0400, a5);
      idle(1);
      issue(1'b0, 32'h0000_0400, '0);
      idle(2);

      // Back-to-back: write, then read with enable held high
      issue(1'b1, 32'h0000_0800, rnd256());
      issue(1'b0, 32'h0000_0400, '0);
      idle(1);

      // Abort, then confirm the line is untouched and no ack appeared
      abort_req(1'b1, 32'h0000_0400, 256'h1, 3);
      idle(L + 2);
      issue(1'b0, 32'h0000_0400, '0);
      idle(1);

      // Offset bits and aliasing above the array
      issue(1'b0, 32'h0000_041C, '0);
      idle(1);
      issue(1'b1, 32'h0000_0000, rnd256());
      idle(1);
      issue(1'b1, 32'h0000_4000, 256'hFF);
      idle(1);
      issue(1'b0, 32'h0000_0000, '0);
      idle(1);

      // Reset in the middle of a write
      dc = rnd256();
      issue(1'b1, 32'h0000_0C00, dc);
      idle(1);
      write_i  = 1'b1;
      addr_i   = 32'h0000_0C00;
      data_i   = ~dc;
      enable_i = 1'b1;
      acc = cyc + 1;
      while (cyc < acc + 5) @(negedge clk);
      rst_i = 1'b0;
      #1;
      chk_int("midop_reset_ack", 32'(ack_o), 0);
      chk_vec("midop_reset_data", data_o, '0);
      last_read = '0;
      @(negedge clk);
      @(negedge clk);
      enable_i = 1'b0;
      rst_i    = 1'b1;
      next_ok  = 0;
      @(negedge clk);
      issue(1'b0, 32'h0000_0C00, '0);
      idle(1);

      // Randomized traffic over 16 lines with offsets, aliasing and aborts
      for (int i = 0; i < 16; i++) begin
         issue(1'b1, 32'h0000_1000 + 32'(i * 32), rnd256());
         idle($urandom_range(0, 1));
      end
      for (int i = 0; i < 40; i++) begin
         ln = 128 + $urandom_range(0, 15);
         a  = 32'(ln * 32) | 32'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) a = a | ($urandom << (IDX_W + 5));
         if ($urandom_range(0, 7) == 0) begin
            abort_req($urandom_range(0, 1) == 1, a, rnd256(), $urandom_range(0, L - 2));
         end else begin
            issue($urandom_range(0, 1) == 1, a, rnd256());
            idle($urandom_range(0, 2));
         end
      end

      idle(L + 3);
      chk_int("queue_empty", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
